// File: rtl/pipe_scroller_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_scroller_if
//  Description : Control, tick and render-port bundle for pipe_scroller.
//                The master side (game controller / tick generator /
//                renderer) drives requests; the slave side (the scroller)
//                returns playfield state.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_scroller_if #(
  parameter int COLS = 16,
  parameter int ROWS = 16
);

  localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  // Game control and pipe-speed tick
  logic               start;
  logic               pause;
  logic               activate;
  logic [c_ROW_W-1:0] bird_row;

  // Renderer column read port
  logic [c_COL_W-1:0] rd_col;
  logic [ROWS-1:0]    rd_data;

  // Status back to the game controller
  logic               running;
  logic               shifted;
  logic               collide;
  logic [7:0]         score;

  modport master (
    output start, pause, activate, bird_row, rd_col,
    input  rd_data, running, shifted, collide, score
  );

  modport slave (
    input  start, pause, activate, bird_row, rd_col,
    output rd_data, running, shifted, collide, score
  );

endinterface
`default_nettype wire

// File: rtl/pipe_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_scroller
//  Description : Scrolling pipe playfield. Each accepted pipe-speed tick
//                shifts the COLS x ROWS occupancy grid one column left and
//                periodically injects a new pipe column whose gap position
//                comes from a free-running LFSR. Detects the bird hitting a
//                wall and counts pipes that have passed the bird.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_scroller #(
  parameter int          COLS        = 16,
  parameter int          ROWS        = 16,
  parameter int          GAP         = 4,
  parameter int          SPAWN_EVERY = 4,
  parameter int          BIRD_COL    = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic           clk,
  input  logic           reset,
  pipe_scroller_if.slave bus
);

  localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_SPW_W = $clog2(SPAWN_EVERY);

  localparam logic [c_SPW_W-1:0] c_SPW_LAST = c_SPW_W'(SPAWN_EVERY - 1);
  localparam logic [c_ROW_W:0]   c_ROWS_EXT = (c_ROW_W + 1)'(ROWS);
  localparam logic [c_COL_W:0]   c_COLS_EXT = (c_COL_W + 1)'(COLS);
  localparam logic [31:0]        c_GAP_MAX  = 32'(ROWS - GAP);
  localparam logic [31:0]        c_GAP_LEN  = 32'(GAP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_running;
  logic               w_accept;

  logic [ROWS-1:0]    r_field [COLS];
  logic [15:0]        r_lfsr;
  logic [c_SPW_W-1:0] r_spawn_cnt;
  logic [7:0]         r_score;
  logic               r_collide;
  logic               r_shifted;

  logic               w_lfsr_fb;
  logic [31:0]        w_gap;
  logic [ROWS-1:0]    w_mask;
  logic               w_spawn;
  logic [ROWS-1:0]    w_bird_col;
  logic               w_bird_ok;
  logic               w_hit;
  logic               w_rd_ok;

  // --------------------------------------------------------------------------
  // Gap generator: Fibonacci LFSR (taps 16,14,13,11) advancing every cycle in
  // every state, so the gap pattern depends on when the player starts.
  // --------------------------------------------------------------------------
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Free-running LFSR; a non-zero seed keeps it out of the all-zero lock-up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Gap start row: low nibble of the LFSR, clamped so the gap fits the column
  always_comb begin
    w_gap = 32'(r_lfsr[3:0]);
    if (w_gap > c_GAP_MAX) begin
      w_gap = c_GAP_MAX;
    end
  end

  // Spawn mask: wall everywhere except rows w_gap .. w_gap+GAP-1
  for (genvar r = 0; r < ROWS; r++) begin : g_mask
    assign w_mask[r] = (32'(r) < w_gap) || (32'(r) >= (w_gap + c_GAP_LEN));
  end

  assign w_spawn = (r_spawn_cnt == '0);

  // --------------------------------------------------------------------------
  // Collision probe. Out-of-range bird rows read as an empty cell.
  // --------------------------------------------------------------------------
  assign w_bird_col = r_field[BIRD_COL];
  assign w_bird_ok  = ({1'b0, bus.bird_row} < c_ROWS_EXT);
  assign w_hit      = w_bird_ok && w_bird_col[bus.bird_row];

  // --------------------------------------------------------------------------
  // Game state machine
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and tick acceptance; a hit outranks a same-cycle tick
  always_comb begin
    w_state_nxt = r_state;
    w_running   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_running = 1'b1;
        w_accept  = bus.activate & ~bus.pause & ~w_hit;
        if (w_hit) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Playfield: each column takes its right neighbour on an accepted tick;
  // the entry column loads a fresh pipe or an empty column.
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS - 1) begin : g_entry
      // Entry column: new pipe on spawn ticks, empty otherwise
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_field[c] <= '0;
        end else if (w_accept) begin
          r_field[c] <= w_spawn ? w_mask : '0;
        end
      end
    end else begin : g_body
      // Interior column: scroll one step left
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_field[c] <= '0;
        end else if (w_accept) begin
          r_field[c] <= r_field[c+1];
        end
      end
    end
  end

  // Spawn phase, pass counter and shift strobe, all advanced by accepted ticks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spawn_cnt <= '0;
      r_score     <= 8'd0;
      r_shifted   <= 1'b0;
    end else begin
      r_shifted <= w_accept;
      if (w_accept) begin
        r_spawn_cnt <= (r_spawn_cnt == c_SPW_LAST) ? '0 : r_spawn_cnt + 1'b1;
        // A pipe sitting in the bird column is about to leave it: one pass
        if ((|w_bird_col) && (r_score != 8'hFF)) begin
          r_score <= r_score + 8'd1;
        end
      end
    end
  end

  // Sticky collision flag, set on the cycle the bird cell is a wall in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_collide <= 1'b0;
    end else if ((r_state == ST_RUN) && w_hit) begin
      r_collide <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign w_rd_ok     = ({1'b0, bus.rd_col} < c_COLS_EXT);
  assign bus.rd_data = w_rd_ok ? r_field[bus.rd_col] : '0;
  assign bus.running = w_running;
  assign bus.shifted = r_shifted;
  assign bus.collide = r_collide;
  assign bus.score   = r_score;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_scroller
//  Description : Self-checking bench for pipe_scroller against a behavioural
//                playfield model with randomized tick/pause/bird stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_scroller;

  localparam int          COLS        = 16;
  localparam int          ROWS        = 16;
  localparam int          GAP         = 4;
  localparam int          SPAWN_EVERY = 4;
  localparam int          BIRD_COL    = 4;
  localparam logic [15:0] SEED        = 16'hACE1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pipe_scroller_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  pipe_scroller #(
    .COLS(COLS), .ROWS(ROWS), .GAP(GAP), .SPAWN_EVERY(SPAWN_EVERY),
    .BIRD_COL(BIRD_COL), .LFSR_SEED(SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  // Reference model
  logic [ROWS-1:0] m_field [COLS];
  logic [15:0]     m_lfsr;
  int              m_ticks;
  int              m_score;
  int              m_state;   // 0 idle, 1 run, 2 halt
  bit              m_collide;
  bit              m_shifted;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  function automatic logic [ROWS-1:0] gap_mask(input logic [15:0] v);
    int g;
    logic [ROWS-1:0] m;
    g = int'(v) % 16;
    if (g > ROWS - GAP) g = ROWS - GAP;
    m = '1;
    for (int i = 0; i < GAP; i++) m[g+i] = 1'b0;
    return m;
  endfunction

  function automatic int safe_row();
    int q[$];
    if (m_field[BIRD_COL] == '0) return $urandom_range(ROWS - 1);
    for (int r = 0; r < ROWS; r++) if (!m_field[BIRD_COL][r]) q.push_back(r);
    return q[$urandom_range(q.size() - 1)];
  endfunction

  function automatic int wall_row();
    int q[$];
    for (int r = 0; r < ROWS; r++) if (m_field[BIRD_COL][r]) q.push_back(r);
    if (q.size() == 0) return 0;
    return q[$urandom_range(q.size() - 1)];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) m_field[c] = '0;
    m_lfsr    = SEED;
    m_ticks   = 0;
    m_score   = 0;
    m_state   = 0;
    m_collide = 1'b0;
    m_shifted = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("running", 32'(bus.running), 32'(m_state == 1));
    check("shifted", 32'(bus.shifted), 32'(m_shifted));
    check("collide", 32'(bus.collide), 32'(m_collide));
    check("score",   32'(bus.score),   32'(m_score));
  endtask

  task automatic check_field();
    for (int c = 0; c < COLS; c++) begin
      bus.rd_col = 4'(c);
      #1;
      check($sformatf("rd_data[%0d]", c), 32'(bus.rd_data), 32'(m_field[c]));
    end
  endtask

  // One clock: drive inputs, advance the model by the game rules, then check
  task automatic cycle(input bit st, input bit ps, input bit ac, input int br);
    bit hit, acc;
    bus.start    = st;
    bus.pause    = ps;
    bus.activate = ac;
    bus.bird_row = 4'(br);
    hit = (m_state == 1) && m_field[BIRD_COL][br];
    acc = (m_state == 1) && ac && !ps && !hit;
    m_shifted = acc;
    if (acc) begin
      if (m_field[BIRD_COL] != '0 && m_score < 255) m_score++;
      for (int c = 0; c < COLS - 1; c++) m_field[c] = m_field[c+1];
      m_field[COLS-1] = (m_ticks % SPAWN_EVERY == 0) ? gap_mask(m_lfsr) : '0;
      m_ticks++;
    end
    if (m_state == 0 && st) m_state = 1;
    else if (m_state == 1 && hit) begin
      m_state   = 2;
      m_collide = 1'b1;
    end
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge clk);
    #1;
    check_outputs();
    check_field();
  endtask

  initial begin
    int guard;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.activate = 1'b0;
    bus.bird_row = '0;
    bus.rd_col   = '0;

    // Reset state
    #5;
    model_reset();
    check_outputs();
    check_field();
    @(negedge clk) reset = 1'b1;

    // IDLE ignores activate
    repeat (3) cycle(0, 0, 1, safe_row());
    cycle(1, 0, 0, safe_row());

    // First tick spawns
    cycle(0, 0, 1, safe_row());
    bus.rd_col = 4'd15;
    #1;
    check("spawn_gap_rows", 32'($countones(~bus.rd_data)), 32'(GAP));
    cycle(0, 0, 0, safe_row());

    // Ticks 2..5: second spawn on tick 5
    repeat (4) cycle(0, 0, 1, safe_row());
    bus.rd_col = 4'd11;
    #1;
    check("col11_pipe", 32'(|bus.rd_data), 32'd1);
    bus.rd_col = 4'd13;
    #1;
    check("col13_empty", 32'(bus.rd_data), 32'd0);

    // Paused ticks are dropped
    repeat (10) cycle(0, 1, 1, safe_row());
    cycle(0, 0, 1, safe_row());

    // Long randomized run past score saturation
    guard = 0;
    while (m_ticks < 1040 && guard < 6000) begin
      cycle(0, ($urandom_range(7) == 0), ($urandom_range(3) != 0), safe_row());
      if (m_shifted && m_ticks == 13) check("score_after_13", 32'(bus.score), 32'd1);
      guard++;
    end
    check("tick_budget", 32'(m_ticks >= 1040), 32'd1);
    check("score_sat", 32'(bus.score), 32'd255);

    // Reset mid-RUN with pipes present
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_field();
    @(negedge clk) reset = 1'b1;

    // Restart and scroll until a pipe sits in the bird column
    cycle(1, 0, 0, safe_row());
    guard = 0;
    while (m_field[BIRD_COL] == '0 && guard < 100) begin
      cycle(0, 0, 1, safe_row());
      guard++;
    end
    check("pipe_reached_bird", 32'(m_field[BIRD_COL] != '0), 32'd1);

    // Collision wins over a same-cycle tick, then everything is frozen
    cycle(0, 0, 1, wall_row());
    check("collide_set", 32'(bus.collide), 32'd1);
    repeat (5) cycle(1'($urandom_range(1)), 0, 1, $urandom_range(ROWS - 1));

    // Reset clears HALT
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_field();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Consumer of the pipe-speed tick. Holds the scrolling pipe playfield (COLS x ROWS occupancy grid).
- On each accepted tick: shifts every column one step left and injects a new pipe column every SPAWN_EVERY ticks, with an LFSR-chosen gap.
- Checks the bird cell for collision and keeps the score.
- Sits between the pipe-speed tick generator and the LED-matrix renderer / game controller.

Parameters:
- COLS, 16, playfield width in columns; column COLS-1 is the entry (right edge), column 0 is the exit.
- ROWS, 16, playfield height in rows.
- GAP, 4, pipe gap height in rows (1 <= GAP < ROWS).
- SPAWN_EVERY, 4, accepted ticks between pipe spawns (>= 2).
- BIRD_COL, 4, fixed column occupied by the bird.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; leaves IDLE.
- pause  in  1  freezes scrolling, spawn count and score.
- activate  in  1  one-cycle shift tick from the pipe-speed generator.
- bird_row  in  $clog2(ROWS)  current bird row.
- rd_col  in  $clog2(COLS)  renderer column select.
- rd_data  out  ROWS  combinational occupancy of column rd_col (1 = wall).
- running  out  1  high in RUN.
- shifted  out  1  one-cycle pulse, registered, on the cycle after an accepted shift.
- collide  out  1  registered, sticky in HALT.
- score  out  8  pipes passed, saturating at 255.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE; all field columns 0; score 0; collide 0; shifted 0; spawn_cnt 0; lfsr LFSR_SEED.
  - running=0.
  - Applies immediately, including mid-RUN or in HALT.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk cycle in every state.
  - Never 0.
- Gap position: g = lfsr[3:0] clamped to ROWS-GAP (g = ROWS-GAP when lfsr[3:0] > ROWS-GAP).
- Spawn mask: all ones except rows g..g+GAP-1, which are 0.
- States:
  - IDLE: field static. start=1 -> RUN next cycle. activate is ignored.
  - RUN: accepted tick = activate & ~pause & ~hit, where hit = field[BIRD_COL][bird_row].
  - HALT: everything frozen; start and activate are ignored; exit only via reset.
- Accepted tick, applied at the next edge:
  - field[i] <= field[i+1] for i < COLS-1.
  - field[COLS-1] <= spawn mask if spawn_cnt==0, else 0.
  - spawn_cnt <= (spawn_cnt==SPAWN_EVERY-1) ? 0 : spawn_cnt+1.
  - score <= score+1, saturating, if field[BIRD_COL] != 0 before the shift (pipe leaving the bird column).
  - shifted <= 1 for exactly one cycle.
- The first tick after start always spawns (spawn_cnt=0).
- Collision:
  - Evaluated every RUN cycle, including while paused.
  - hit=1 -> collide<=1, state HALT.
  - A hit in the same cycle as activate wins: no shift, no score, no shifted pulse.
- pause=1 with activate=1: tick is dropped, not deferred.
- rd_data: pure combinational read of the current registered field. Zero latency.
- Width rule: bird_row / rd_col >= ROWS / COLS -> treated as empty cell / rd_data 0 (no collision).

Test Plan:
1. Reset mid-RUN with pipes present -> same cycle: all rd_data 0, score 0, running 0, collide 0. After release, the first LFSR value equals LFSR_SEED's successor.
2. start, then one activate pulse -> next cycle:
   - shifted=1 for one cycle.
   - rd_col=15 has exactly 4 contiguous zero rows starting at g <= 12; columns 0..14 are 0.
3. Five accepted ticks -> pipes in columns 15 and 11 (second spawn on tick 5); columns 12..14 are 0.
4. pause=1 while 10 activate pulses arrive -> field, score and spawn_cnt unchanged, no shifted pulse. After pause=0, the next tick behaves as if the paused ticks never occurred.
5. Bench reads the gap of the first pipe, holds bird_row inside it -> after tick 12 the pipe is at column 4 with no collide; after tick 13 score=1. Run to 255 passes, then one more -> score stays 255.
6. bird_row set to a wall row while the pipe is at column 4, with activate in the same cycle -> collide=1 next cycle, running=0, no shift. Further activate/start -> no change. reset=0 -> all cleared.
